inst_fetch: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline; drives the decode stage's instruction/PC inputs and consumes its pause and next-PC outputs.
- Owns the PC register and the instruction-memory request handshake (req/gnt, then rvalid).
- Absorbs decode stalls with a 1-entry skid buffer.
- Honours MIPS branch-delay-slot semantics.

---
 rtl/inst_fetch_pkg.sv | 23 ++
 rtl/inst_fetch_skid_buf.sv | 41 ++++
 rtl/inst_fetch.sv | 140 ++++++++++++++
 tb/tb_inst_fetch.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_skid_buf.sv
// One-entry {inst,pc} skid buffer that absorbs a response while decode is stalled.
module fetch_skid_buf
  import inst_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t rd_entry,
  output logic         full
);

  fetch_entry_t data_r;
  logic         full_r;

  // Storage and occupancy; a push in the same cycle as a pop refills the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= fetch_entry_t'(64'h0);
      full_r <= 1'b0;
    end else begin
      if (push) begin
        data_r <= wr_entry;
      end else begin
        data_r <= data_r;
      end
      if (push) begin
        full_r <= 1'b1;
      end else if (pop) begin
        full_r <= 1'b0;
      end else begin
        full_r <= full_r;
      end
    end
  end

  assign rd_entry = data_r;
  assign full     = full_r;

endmodule

// File: rtl/inst_fetch.sv
// MIPS fetch stage: PC register, single-outstanding imem handshake, skid buffer, delay-slot redirect.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause_i,
  input  logic        redirect_i,
  input  logic [31:0] newpc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  fetch_state_e state_r, state_s;
  logic [31:0]  next_pc_r, next_pc_s, pend_pc_r, pend_pc_s, req_pc_r;
  logic         pend_r, pend_s, req_r;
  logic [31:0]  inst_r, pc_r;
  logic         valid_r;
  logic         hold_s, grant_s, resp_s, take_s, slot_open_s;
  logic         push_s, pop_s, skid_full_s;
  fetch_entry_t skid_entry_s, resp_entry_s;

  assign hold_s       = valid_r && pause_i;
  assign grant_s      = (state_r == REQ) && imem_gnt_i;
  assign resp_s       = (state_r == WAIT) && imem_rvalid_i;
  assign take_s       = redirect_i && valid_r && !pause_i;
  assign slot_open_s  = (next_pc_r == pc_inc(pc_r));
  assign push_s       = resp_s && (hold_s || skid_full_s);
  assign pop_s        = skid_full_s && !hold_s;
  assign resp_entry_s = '{inst: imem_rdata_i, pc: req_pc_r};

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (rst),
    .push     (push_s),
    .pop      (pop_s),
    .wr_entry (resp_entry_s),
    .rd_entry (skid_entry_s),
    .full     (skid_full_s)
  );

  // Fetch FSM next state; a full skid parks the FSM in IDLE so it cannot overflow.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (!skid_full_s) state_s = REQ;  else state_s = IDLE;
      REQ:     if (imem_gnt_i)   state_s = WAIT; else state_s = REQ;
      WAIT:    if (imem_rvalid_i) state_s = IDLE; else state_s = WAIT;
      default: state_s = IDLE;
    endcase
  end

  // Next-PC selection; a redirect waits in pend until the delay slot is granted.
  always_comb begin
    next_pc_s = next_pc_r;
    pend_s    = pend_r;
    pend_pc_s = pend_pc_r;
    if (take_s && !slot_open_s) begin
      next_pc_s = newpc_i;
    end else if (grant_s) begin
      if (take_s) begin
        next_pc_s = newpc_i;
      end else if (pend_r) begin
        next_pc_s = pend_pc_r;
        pend_s    = 1'b0;
      end else begin
        next_pc_s = pc_inc(next_pc_r);
      end
    end else if (take_s) begin
      pend_s    = 1'b1;
      pend_pc_s = newpc_i;
    end else begin
      next_pc_s = next_pc_r;
    end
  end

  // Control state, PC and request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      req_r     <= 1'b0;
      next_pc_r <= RESET_PC;
      pend_r    <= 1'b0;
      pend_pc_r <= 32'h0000_0000;
      req_pc_r  <= RESET_PC;
    end else begin
      state_r   <= state_s;
      req_r     <= (state_s == REQ);
      next_pc_r <= next_pc_s;
      pend_r    <= pend_s;
      pend_pc_r <= pend_pc_s;
      if (grant_s) begin
        req_pc_r <= next_pc_r;
      end else begin
        req_pc_r <= req_pc_r;
      end
    end
  end

  // Decode-facing output register: hold, else skid, else response, else bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_r  <= NOP_INST;
      pc_r    <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else if (hold_s) begin
      inst_r  <= inst_r;
      pc_r    <= pc_r;
      valid_r <= valid_r;
    end else if (skid_full_s) begin
      inst_r  <= skid_entry_s.inst;
      pc_r    <= skid_entry_s.pc;
      valid_r <= 1'b1;
    end else if (resp_s) begin
      inst_r  <= imem_rdata_i;
      pc_r    <= req_pc_r;
      valid_r <= 1'b1;
    end else begin
      inst_r  <= NOP_INST;
      pc_r    <= pc_r;
      valid_r <= 1'b0;
    end
  end

  assign imem_req_o  = req_r;
  assign imem_addr_o = next_pc_r;
  assign inst_o      = inst_r;
  assign pc_o        = pc_r;
  assign valid_o     = valid_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a small instruction-memory responder in the step task.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        pause_i, redirect_i;
  logic [31:0] newpc_i;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic [31:0] inst_o, pc_o;
  logic        valid_o;

  int          checks = 0;
  int          failures = 0;

  int          gnt_delay, rv_delay, gnt_cnt, rv_cnt;
  logic        busy;
  logic [31:0] out_addr, last_gnt;
  logic        saw_3010;
  int          n;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  inst_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .pause_i       (pause_i),
    .redirect_i    (redirect_i),
    .newpc_i       (newpc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory inputs for this cycle, advance past the edge, update the model.
  task automatic step();
    logic g, r, req_before;
    g = 1'b0;
    r = 1'b0;
    req_before = imem_req_o;
    if (busy) begin
      if (rv_cnt >= rv_delay) r = 1'b1;
    end else if (imem_req_o) begin
      if (gnt_cnt >= gnt_delay) g = 1'b1;
    end
    imem_gnt_i    = g;
    imem_rvalid_i = r;
    imem_rdata_i  = r ? (out_addr ^ KEY) : 32'hDEAD_BEEF;
    if (g) begin
      last_gnt = imem_addr_o;
      if (imem_addr_o == 32'h0000_3010) saw_3010 = 1'b1;
    end
    @(posedge clk);
    #1;
    if (g) begin
      busy = 1'b1; out_addr = last_gnt; rv_cnt = 1; gnt_cnt = 0;
    end else begin
      if (req_before) gnt_cnt++;
      if (busy) begin
        if (r) busy = 1'b0;
        else rv_cnt++;
      end
    end
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp_pc, output int cyc);
    cyc = 0;
    do begin step(); cyc++; end while (!valid_o && cyc < 40);
    check({tag, "_valid"}, {31'h0, valid_o}, 32'h1);
    check({tag, "_pc"}, pc_o, exp_pc);
    check({tag, "_inst"}, inst_o, exp_pc ^ KEY);
  endtask

  initial begin
    rst = 1'b0; pause_i = 1'b0; redirect_i = 1'b0; newpc_i = 32'h0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    gnt_delay = 0; rv_delay = 1; gnt_cnt = 0; rv_cnt = 0; busy = 1'b0;
    out_addr = 32'h0; last_gnt = 32'h0; saw_3010 = 1'b0;

    #12;
    check("rst_inst", inst_o, 32'h0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_valid", {31'h0, valid_o}, 32'h0);
    check("rst_req", {31'h0, imem_req_o}, 32'h0);
    check("rst_addr", imem_addr_o, 32'h0000_3000);
    rst = 1'b1;

    // Streaming at best-case rate
    wait_valid("f3000", 32'h0000_3000, n);
    step();
    check("bubble_valid", {31'h0, valid_o}, 32'h0);
    check("bubble_inst", inst_o, 32'h0);
    check("bubble_pc", pc_o, 32'h0000_3000);
    wait_valid("f3004", 32'h0000_3004, n);
    check("spacing", n, 32'd2);

    // Decode stall: 3008 lands in the skid, 300C must not be requested
    pause_i = 1'b1;
    repeat (10) step();
    check("hold_pc", pc_o, 32'h0000_3004);
    check("hold_valid", {31'h0, valid_o}, 32'h1);
    check("hold_req", {31'h0, imem_req_o}, 32'h0);
    check("hold_last_gnt", last_gnt, 32'h0000_3008);
    pause_i = 1'b0;
    step();
    check("drain_pc", pc_o, 32'h0000_3008);
    check("drain_inst", inst_o, 32'h0000_3008 ^ KEY);

    // Branch at 3008 with delay slot not yet granted
    redirect_i = 1'b1; newpc_i = 32'h0000_3100;
    step();
    redirect_i = 1'b0;
    wait_valid("slot300c", 32'h0000_300C, n);
    wait_valid("t3100", 32'h0000_3100, n);
    wait_valid("t3104", 32'h0000_3104, n);

    // Branch at 3104 with delay slot 3108 already fetched into the skid
    pause_i = 1'b1;
    repeat (10) step();
    check("hold2_last_gnt", last_gnt, 32'h0000_3108);
    pause_i = 1'b0; redirect_i = 1'b1; newpc_i = 32'h0000_3200;
    step();
    redirect_i = 1'b0;
    check("slot3108_pc", pc_o, 32'h0000_3108);
    wait_valid("t3200", 32'h0000_3200, n);

    // Slow memory: grant after 4 waiting cycles, rvalid 5 cycles after grant
    gnt_delay = 4; rv_delay = 5;
    step();
    for (int i = 0; i < 4; i++) begin
      check("slow_req", {31'h0, imem_req_o}, 32'h1);
      check("slow_addr", imem_addr_o, 32'h0000_3204);
      step();
    end
    for (int i = 0; i < 12; i++) begin
      if (valid_o) break;
      check("slow_bubble_inst", inst_o, 32'h0);
      step();
    end
    check("slow_valid", {31'h0, valid_o}, 32'h1);
    check("slow_pc", pc_o, 32'h0000_3204);

    // Asynchronous reset while a request is outstanding
    gnt_delay = 0;
    step();
    step();
    check("pre_rst_busy", {31'h0, busy}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_inst", inst_o, 32'h0);
    check("arst_pc", pc_o, 32'h0);
    check("arst_valid", {31'h0, valid_o}, 32'h0);
    check("arst_req", {31'h0, imem_req_o}, 32'h0);
    check("arst_addr", imem_addr_o, 32'h0000_3000);
    busy = 1'b0; gnt_cnt = 0; rv_cnt = 0; rv_delay = 1;
    #1;
    rst = 1'b1;
    n = 0;
    do begin step(); n++; end while (!imem_req_o && n < 10);
    check("post_rst_req", {31'h0, imem_req_o}, 32'h1);
    check("post_rst_addr", imem_addr_o, 32'h0000_3000);

    // PC wrap through a redirect to FFFF_FFFC
    wait_valid("w3000", 32'h0000_3000, n);
    redirect_i = 1'b1; newpc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    wait_valid("w3004", 32'h0000_3004, n);
    wait_valid("wfffc", 32'hFFFF_FFFC, n);
    wait_valid("w0000", 32'h0000_0000, n);

    check("no_3010", {31'h0, saw_3010}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
